aes_req_sequencer: RTL and testbench

AES_REQ_SEQUENCER -- requirements
Module: aes_req_sequencer

---
 rtl/aes_req_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_aes_req_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_req_sequencer.sv
// aes_req_sequencer: single-request sequencer around an AES core.
// Accepts one request, loads the core, waits for core_done, then holds the
// result until the downstream handshake completes.
//
// Optional feature: define AES_SEQ_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYC cycles. The aborted result has out_err=1 and out_text=0.
// Without the macro, WAIT never times out, out_err is tied low and there is
// no timeout counter.

module aes_req_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [127:0]       in_key,
  input  logic [127:0]       in_text,
  output logic               core_ld,
  output logic               core_mode,
  output logic [127:0]       core_key,
  output logic [127:0]       core_text,
  input  logic [127:0]       core_text_out,
  input  logic               core_done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_text,
  output logic               out_mode,
  output logic               out_err,
  output logic [CNT_W-1:0]   blk_cnt
);

  localparam int unsigned DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  // Qualified events for the current cycle
  logic accept;
  logic done_ok;
  logic tmo_hit;
  logic hs;

  // Next values of the registered outputs
  logic              in_ready_nxt;
  logic              core_ld_nxt;
  logic              out_valid_nxt;
  logic [DATA_W-1:0] out_text_nxt;
  logic              out_mode_nxt;
  logic [CNT_W-1:0]  blk_cnt_nxt;

  // Accept only in IDLE once in_ready is up; in_ready itself is a flop.
  assign accept  = (state == IDLE) && in_valid && in_ready;
  // core_done matters only in WAIT; elsewhere it is ignored.
  assign done_ok = (state == WAIT) && core_done;
  // Downstream handshake on the held result.
  assign hs      = (state == HOLD) && out_valid && out_ready;

`ifdef AES_SEQ_TIMEOUT_EN
  // Counter range covers 0 .. TIMEOUT_CYC-1; the terminal count is the last WAIT cycle.
  localparam int unsigned TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;
  logic             err_nxt;

  // A core_done on the terminal count wins over the abort.
  assign tmo_hit = (state == WAIT) && !core_done &&
                   (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  // Timeout counter: cleared on entry to WAIT, counts WAIT cycles without done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (state == LOAD) begin
      tmo_cnt <= '0;
    end else if ((state == WAIT) && !core_done) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // Error flag register for the returned block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_nxt;
    end
  end

  assign out_err = err_q;
`else
  // TIMEOUT_CYC only matters when the timeout feature is built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYC);

  assign tmo_hit = 1'b0;
  assign out_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    state_nxt = WAIT;
      WAIT:    if (done_ok || tmo_hit) state_nxt = HOLD;
      HOLD:    if (hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs.
  always_comb begin
    in_ready_nxt  = (state_nxt == IDLE);
    core_ld_nxt   = (state_nxt == LOAD);
    out_valid_nxt = out_valid;
    out_text_nxt  = out_text;
    out_mode_nxt  = out_mode;
    blk_cnt_nxt   = blk_cnt;
`ifdef AES_SEQ_TIMEOUT_EN
    err_nxt       = err_q;
`endif
    if (done_ok) begin
      out_valid_nxt = 1'b1;
      out_text_nxt  = core_text_out;
      out_mode_nxt  = core_mode;
      blk_cnt_nxt   = blk_cnt + CNT_W'(1);
`ifdef AES_SEQ_TIMEOUT_EN
      err_nxt       = 1'b0;
`endif
    end else if (tmo_hit) begin
      out_valid_nxt = 1'b1;
      out_text_nxt  = '0;
      out_mode_nxt  = core_mode;
`ifdef AES_SEQ_TIMEOUT_EN
      err_nxt       = 1'b1;
`endif
    end else if (hs) begin
      out_valid_nxt = 1'b0;
    end
  end

  // Output and holding registers; the core-side holding regs load only on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready  <= 1'b0;
      core_ld   <= 1'b0;
      core_mode <= 1'b0;
      core_key  <= '0;
      core_text <= '0;
      out_valid <= 1'b0;
      out_text  <= '0;
      out_mode  <= 1'b0;
      blk_cnt   <= '0;
    end else begin
      in_ready  <= in_ready_nxt;
      core_ld   <= core_ld_nxt;
      out_valid <= out_valid_nxt;
      out_text  <= out_text_nxt;
      out_mode  <= out_mode_nxt;
      blk_cnt   <= blk_cnt_nxt;
      if (accept) begin
        core_mode <= in_mode;
        core_key  <= in_key;
        core_text <= in_text;
      end
    end
  end

endmodule

// File: tb/tb_aes_req_sequencer.sv
// Bench for aes_req_sequencer: table of directed requests plus hand-written
// sequences for spurious core_done, reset during WAIT, counter wrap and
// (with AES_SEQ_TIMEOUT_EN) the timeout abort.

module tb_aes_req_sequencer;

  localparam logic [127:0] AES_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] AES_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] AES_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] JUNK    = 128'hdeadbeef_cafef00d_0badc0de_a5a5a5a5;

`ifdef AES_SEQ_TIMEOUT_EN
  // With an 8-cycle timeout the first vector lands done on the terminal count.
  localparam int D0 = 8;
`else
  localparam int D0 = 12;
`endif

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [127:0] in_key;
  logic [127:0] in_text;
  logic         core_ld;
  logic         core_mode;
  logic [127:0] core_key;
  logic [127:0] core_text;
  logic [127:0] core_text_out;
  logic         core_done;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_text;
  logic         out_mode;
  logic         out_err;
  logic [3:0]   blk_cnt;

  int checks;
  int errors;

  aes_req_sequencer #(
    .TIMEOUT_CYC (8),
    .CNT_W       (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_mode       (in_mode),
    .in_key        (in_key),
    .in_text       (in_text),
    .core_ld       (core_ld),
    .core_mode     (core_mode),
    .core_key      (core_key),
    .core_text     (core_text),
    .core_text_out (core_text_out),
    .core_done     (core_done),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_text      (out_text),
    .out_mode      (out_mode),
    .out_err       (out_err),
    .blk_cnt       (blk_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core stand-in: known AES pairs for the reference key, xor otherwise.
  function automatic logic [127:0] core_fn(input logic m, input logic [127:0] k,
                                           input logic [127:0] t);
    if (k == AES_KEY && m == 1'b0 && t == AES_PT) return AES_CT;
    if (k == AES_KEY && m == 1'b1 && t == AES_CT) return AES_PT;
    return t ^ k;
  endfunction

  // Result bus carries junk except during the done pulse.
  always_comb core_text_out = core_done ? core_fn(core_mode, core_key, core_text) : JUNK;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic         mode;
    logic [127:0] key;
    logic [127:0] text;
    int           d;
    int           hold;
    logic         ld_done;
    logic [127:0] exp_text;
    logic         exp_mode;
    logic [3:0]   exp_cnt;
  } vec_t;

  vec_t vecs [5];

  // One full request; done arrives d cycles after the LOAD cycle.
  task automatic do_req(input logic m, input logic [127:0] k, input logic [127:0] t,
                        input int d, input int hold, input logic ld_done,
                        input logic [127:0] et, input logic em, input logic [3:0] ec,
                        input logic ee);
    int n;
    n = 0;
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    in_mode  = m;
    in_key   = k;
    in_text  = t;
    @(negedge clk);
    in_valid = 1'b0;
    in_mode  = ~m;
    in_key   = ~k;
    in_text  = ~t;
    chk("ld_pulse", 128'(core_ld), 128'd1);
    chk("ld_key", core_key, k);
    chk("ld_text", core_text, t);
    chk("ld_mode", 128'(core_mode), 128'(m));
    chk("ld_ready", 128'(in_ready), 128'd0);
    core_done = ld_done;
    out_ready = 1'b1;
    for (int c = 2; c <= d + 1; c++) begin
      @(negedge clk);
      core_done = (c == d + 1);
      out_ready = (c != d + 1);
      chk("wait_quiet", 128'({core_ld, out_valid, in_ready, core_key == k, core_text == t}),
          128'(5'b00011));
    end
    @(negedge clk);
    core_done = 1'b0;
    out_ready = 1'b0;
    chk("res_valid", 128'(out_valid), 128'd1);
    chk("res_text", out_text, et);
    chk("res_mode", 128'(out_mode), 128'(em));
    chk("res_err", 128'(out_err), 128'(ee));
    chk("res_cnt", 128'(blk_cnt), 128'(ec));
    chk("res_ready", 128'(in_ready), 128'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_stable", 128'({out_valid, in_ready, out_mode, out_err, out_text == et, blk_cnt}),
          128'({1'b1, 1'b0, em, ee, 1'b1, ec}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("hs_valid", 128'(out_valid), 128'd0);
    chk("hs_ready", 128'(in_ready), 128'd1);
  endtask

  // Bound the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_key    = '0;
    in_text   = '0;
    core_done = 1'b0;
    out_ready = 1'b0;

    vecs[0] = '{1'b0, AES_KEY, AES_PT, D0, 0, 1'b0, AES_CT, 1'b0, 4'd1};
    vecs[1] = '{1'b1, AES_KEY, AES_CT, 3, 0, 1'b0, AES_PT, 1'b1, 4'd2};
    vecs[2] = '{1'b0, AES_KEY, AES_PT, 1, 20, 1'b0, AES_CT, 1'b0, 4'd3};
    vecs[3] = '{1'b0, 128'h0, 128'h1234, 4, 2, 1'b1, 128'h1234, 1'b0, 4'd4};
    vecs[4] = '{1'b1, {128{1'b1}}, 128'h0, 2, 1, 1'b0, {128{1'b1}}, 1'b1, 4'd5};

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_outs", 128'({in_ready, core_ld, core_mode, out_valid, out_mode, out_err, blk_cnt}),
        128'd0);
    chk("rst_data", core_key | core_text | out_text, 128'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rel_ready", 128'(in_ready), 128'd1);

    // core_done and out_ready in IDLE are ignored
    core_done = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_done", 128'({out_valid, in_ready, core_ld, blk_cnt}), 128'({1'b0, 1'b1, 1'b0, 4'd0}));
    end
    core_done = 1'b0;
    out_ready = 1'b0;

    // Directed table
    for (int i = 0; i < 5; i++) begin
      do_req(vecs[i].mode, vecs[i].key, vecs[i].text, vecs[i].d, vecs[i].hold,
             vecs[i].ld_done, vecs[i].exp_text, vecs[i].exp_mode, vecs[i].exp_cnt, 1'b0);
    end

    // Reset during WAIT abandons the request
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_key   = AES_KEY;
    in_text  = AES_PT;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("wrst_outs", 128'({in_ready, core_ld, core_mode, out_valid, out_mode, out_err, blk_cnt}),
        128'd0);
    chk("wrst_data", core_key | core_text | out_text, 128'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("wrst_ready", 128'(in_ready), 128'd1);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    chk("wrst_nores", 128'(out_valid), 128'd0);
    @(negedge clk);
    chk("wrst_after", 128'({out_valid, blk_cnt, in_ready}), 128'({1'b0, 4'd0, 1'b1}));

    // Sixteen good blocks wrap the 4-bit counter back to 0
    for (int i = 0; i < 16; i++) begin
      logic [127:0] k;
      logic [127:0] t;
      k = 128'(i * 3 + 1);
      t = {96'h0, 32'h5a5a0000} | 128'(i);
      do_req(1'(i % 2), k, t, 2, 0, 1'b0, t ^ k, 1'(i % 2), 4'(i + 1), 1'b0);
    end
    chk("wrap_cnt", 128'(blk_cnt), 128'd0);

`ifdef AES_SEQ_TIMEOUT_EN
    // No core_done: abort after 8 WAIT cycles
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_key   = AES_KEY;
    in_text  = AES_PT;
    @(negedge clk);
    in_valid = 1'b0;
    chk("tmo_ld", 128'(core_ld), 128'd1);
    for (int c = 2; c <= 9; c++) begin
      @(negedge clk);
      chk("tmo_wait", 128'(out_valid), 128'd0);
    end
    @(negedge clk);
    chk("tmo_valid", 128'(out_valid), 128'd1);
    chk("tmo_err", 128'(out_err), 128'd1);
    chk("tmo_text", out_text, 128'd0);
    chk("tmo_cnt", 128'(blk_cnt), 128'd0);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    chk("tmo_hold", 128'({out_valid, out_err, out_text == 128'd0, blk_cnt}),
        128'({1'b1, 1'b1, 1'b1, 4'd0}));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("tmo_hs", 128'({out_valid, in_ready}), 128'({1'b0, 1'b1}));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
